// File: rtl/mips_pkg.sv
// Shared Mini-MIPS definitions: instruction field constants used by the
// jump path, the default address width, and the RAS operation decode.
package mips_pkg;

    // Primary opcodes relevant to call/return handling
    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;

    // SPECIAL funct code for jr
    localparam logic [5:0] FN_JR       = 6'b001000;

    // Default address width for the fetch path
    localparam int MIPS_AW = 32;

    // What the return-address stack does in a given cycle
    typedef enum logic [1:0] {
        RAS_IDLE    = 2'b00,
        RAS_PUSH    = 2'b01,
        RAS_POP     = 2'b10,
        RAS_REPLACE = 2'b11   // push and pop retire together
    } ras_op_e;

    // Collapse the two retire strobes into one operation code
    function automatic ras_op_e ras_decode(input logic push, input logic pop);
        ras_op_e op;
        case ({pop, push})
            2'b01:   op = RAS_PUSH;
            2'b10:   op = RAS_POP;
            2'b11:   op = RAS_REPLACE;
            default: op = RAS_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ras_mem.sv
// Storage for the return-address stack: DEPTH x AW registers, one write
// port, one asynchronous read port. Contents are deliberately not reset;
// the owner masks stale data using its occupancy count.
module ras_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = MIPS_AW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [AW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [AW-1:0] rdata_o
);

    logic [AW-1:0] mem_q [DEPTH];

    // Single write port, no reset on the array contents
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack for the Mini-MIPS fetch path. jal pushes its link
// address; jr pops, and the popped top is checked against the real target
// so a one-cycle mispredict pulse can be raised on the following cycle.
module return_addr_stack
    import mips_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = MIPS_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_en,
    input  logic [AW-1:0] push_addr,
    input  logic          pop_en,
    input  logic [AW-1:0] pop_actual,
    output logic          top_valid,
    output logic [AW-1:0] top_addr,
    output logic          mispredict,
    output logic          overflow,
    output logic          underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;           // count spans 0..DEPTH inclusive

    logic [PW-1:0] ptr_q, ptr_d;          // next free slot
    logic [CW-1:0] count_q, count_d;
    logic          misp_q, misp_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic [PW-1:0] top_idx;
    logic [AW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    ras_op_e       op;

    assign op      = ras_decode(push_en, pop_en);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top_idx = ptr_q - PW'(1);

    // A same-cycle push+pop on a non-empty stack overwrites the top in place;
    // every other push (including push+pop on empty) lands in the free slot.
    // Writes are suppressed while reset is held so the edge is fully ignored.
    assign wr_en   = push_en & ~rst;
    assign wr_addr = (op == RAS_REPLACE && !empty) ? top_idx : ptr_q;

    ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (push_addr),
        .raddr_i (top_idx),
        .rdata_o (rd_data)
    );

    // Outputs depend on registered state only; stale memory is hidden when empty
    assign top_valid  = ~empty;
    assign top_addr   = empty ? '0 : rd_data;
    assign mispredict = misp_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

    // Next-state for pointer, count, sticky flags and the prediction check
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        misp_d  = 1'b0;
        case (op)
            RAS_PUSH: begin
                ptr_d = ptr_q + PW'(1);
                if (full) begin
                    ovf_d = 1'b1;             // oldest entry silently lost
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            RAS_POP: begin
                if (empty) begin
                    unf_d  = 1'b1;
                    misp_d = 1'b1;
                end else begin
                    ptr_d   = top_idx;
                    count_d = count_q - CW'(1);
                    misp_d  = (rd_data != pop_actual);
                end
            end
            RAS_REPLACE: begin
                if (empty) begin
                    // Empty pop then push: the push still takes effect
                    unf_d   = 1'b1;
                    misp_d  = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                    count_d = CW'(1);
                end else begin
                    misp_d = (rd_data != pop_actual);   // checked against old top
                end
            end
            default: begin
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            misp_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            misp_q  <= misp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: a queue-based stack model is checked
// against the DUT on every falling edge, plus literal expectations per scenario.
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_en;
    logic [AW-1:0] push_addr;
    logic          pop_en;
    logic [AW-1:0] pop_actual;
    logic          top_valid;
    logic [AW-1:0] top_addr;
    logic          mispredict;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    // Behavioural model: a bounded LIFO of addresses plus flags
    logic [AW-1:0] mq[$];
    logic          m_misp = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .push_en    (push_en),
        .push_addr  (push_addr),
        .pop_en     (pop_en),
        .pop_actual (pop_actual),
        .top_valid  (top_valid),
        .top_addr   (top_addr),
        .mispredict (mispredict),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_misp = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_apply(input logic pu, input logic [AW-1:0] pa,
                               input logic po, input logic [AW-1:0] act);
        m_misp = 1'b0;
        if (po) begin
            if (mq.size() == 0) begin
                m_unf  = 1'b1;
                m_misp = 1'b1;
            end else begin
                m_misp = (mq[$] != act);
                void'(mq.pop_back());
            end
            if (pu) mq.push_back(pa);
        end else if (pu) begin
            mq.push_back(pa);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: model follows the rising edge, returns at the falling edge
    task automatic do_cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_apply(push_en, push_addr, pop_en, pop_actual);
        @(negedge clk);
    endtask

    task automatic step(input bit pu, input logic [AW-1:0] pa,
                        input bit po, input logic [AW-1:0] act);
        push_en    = pu;
        push_addr  = pa;
        pop_en     = po;
        pop_actual = act;
        do_cycle();
        push_en = 1'b0;
        pop_en  = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        do_cycle();
        rst = 1'b0;
    endtask

    // Compare process: every falling edge, DUT vs model
    always @(negedge clk) begin
        if (!done) begin
            chk("top_valid",  AW'(top_valid),  AW'(mq.size() != 0));
            chk("top_addr",   top_addr,        (mq.size() != 0) ? mq[$] : '0);
            chk("mispredict", AW'(mispredict), AW'(m_misp));
            chk("overflow",   AW'(overflow),   AW'(m_ovf));
            chk("underflow",  AW'(underflow),  AW'(m_unf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        push_en = 1'b0; pop_en = 1'b0;
        push_addr = '0; pop_actual = '0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            push_en    = 1'($urandom);
            pop_en     = 1'($urandom);
            push_addr  = $urandom;
            pop_actual = $urandom;
            do_cycle();
        end
        chk("rst_top_valid", AW'(top_valid), '0);
        chk("rst_top_addr",  top_addr,       '0);
        chk("rst_misp",      AW'(mispredict), '0);
        chk("rst_ovf",       AW'(overflow),  '0);
        chk("rst_unf",       AW'(underflow), '0);
        rst = 1'b0; push_en = 1'b0; pop_en = 1'b0;

        // Pop on empty stack
        step(0, '0, 1, 32'h0040_0000);
        chk("empty_pop_misp", AW'(mispredict), 32'd1);
        chk("empty_pop_unf",  AW'(underflow),  32'd1);
        step(0, '0, 0, '0);
        chk("misp_one_cycle", AW'(mispredict), 32'd0);

        // Push/pop order
        reset_dut();
        step(1, 32'h0040_0008, 0, '0);
        step(1, 32'h0040_0020, 0, '0);
        step(1, 32'h0040_0044, 0, '0);
        chk("lifo_top", top_addr, 32'h0040_0044);
        step(0, '0, 1, 32'h0040_0044);
        chk("lifo_pop1_top", top_addr, 32'h0040_0020);
        chk("lifo_pop1_misp", AW'(mispredict), 32'd0);
        step(0, '0, 1, 32'h0040_0020);
        chk("lifo_pop2_top", top_addr, 32'h0040_0008);
        step(0, '0, 1, 32'h0040_0008);
        chk("lifo_empty_valid", AW'(top_valid), 32'd0);
        chk("lifo_empty_addr",  top_addr,       32'd0);
        chk("lifo_no_misp",     AW'(mispredict), 32'd0);

        // Mispredict pulse
        step(1, 32'h0000_1004, 0, '0);
        step(0, '0, 1, 32'h0000_2000);
        chk("bad_pop_misp", AW'(mispredict), 32'd1);
        chk("bad_pop_empty", AW'(top_valid), 32'd0);
        step(0, '0, 0, '0);
        chk("bad_pop_pulse_end", AW'(mispredict), 32'd0);

        // Overflow wrap
        reset_dut();
        for (int i = 1; i <= 9; i++) step(1, AW'(i * 32'h100), 0, '0);
        chk("ovf_flag", AW'(overflow), 32'd1);
        chk("ovf_top",  top_addr,      32'h900);
        for (int i = 9; i >= 2; i--) begin
            chk("ovf_pop_top", top_addr, AW'(i * 32'h100));
            step(0, '0, 1, AW'(i * 32'h100));
        end
        chk("ovf_drained", AW'(top_valid), 32'd0);
        chk("ovf_no_unf",  AW'(underflow), 32'd0);
        step(0, '0, 1, 32'h200);
        chk("ovf_9th_unf",  AW'(underflow),  32'd1);
        chk("ovf_9th_misp", AW'(mispredict), 32'd1);

        // Simultaneous push and pop
        reset_dut();
        step(1, 32'hA0, 0, '0);
        step(1, 32'hB0, 0, '0);
        step(1, 32'hC0, 1, 32'hB0);
        chk("repl_misp", AW'(mispredict), 32'd0);
        chk("repl_top",  top_addr,        32'hC0);
        step(0, '0, 1, 32'hC0);
        chk("repl_next", top_addr, 32'hA0);
        step(0, '0, 1, 32'hA0);
        chk("repl_count2", AW'(top_valid), 32'd0);
        step(1, 32'hD0, 1, 32'h0);
        chk("repl_empty_misp", AW'(mispredict), 32'd1);
        chk("repl_empty_unf",  AW'(underflow),  32'd1);
        chk("repl_empty_top",  top_addr,        32'hD0);
        step(1, 32'hE0, 1, 32'h1234);
        chk("repl_bad_misp", AW'(mispredict), 32'd1);
        chk("repl_bad_top",  top_addr,        32'hE0);

        // Asynchronous reset mid-operation
        reset_dut();
        for (int i = 0; i < 4; i++) step(1, AW'(32'h10 + i), 0, '0);
        step(0, '0, 1, 32'h999);          // leaves a mispredict pending
        #2 rst = 1'b1;
        #1;
        chk("async_valid", AW'(top_valid),  32'd0);
        chk("async_addr",  top_addr,        32'd0);
        chk("async_misp",  AW'(mispredict), 32'd0);
        chk("async_unf",   AW'(underflow),  32'd0);
        model_reset();
        #1 rst = 1'b0;
        step(1, 32'h44, 0, '0);
        chk("async_push_top", top_addr, 32'h44);
        step(0, '0, 1, 32'h44);
        chk("async_count1", AW'(top_valid),  32'd0);
        chk("async_misp0",  AW'(mispredict), 32'd0);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
